// File: rtl/serial_adder_pkg.sv
// Shared FSM encodings and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit-counter width for a given operand width.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder built from two half adders and an OR of their carries.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a sub input that computes a-b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned CNT_W = cnt_w(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               c;
    logic               bit_s;
    logic               bit_c;
    logic               accept;
    logic               last;
    logic               sub_sel;
    logic [WIDTH-1:0]   b_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert b and seed the carry.
    assign b_load = sub_sel ? ~b : b;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    full_adder_bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c),
        .s    (bit_s),
        .cout (bit_c)
    );

    // State register plus registered busy/done decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_SHIFT);
            done  <= (state_next == ST_DONE);
        end
    end

    // Next-state logic; start is only honoured when not shifting.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand shifters, carry flop and result; sum updates only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            acc       <= '0;
            cnt       <= '0;
            c         <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b_load;
            c    <= sub_sel;
            cnt  <= '0;
        end else if (state == ST_SHIFT) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            acc  <= {bit_s, acc[WIDTH-1:1]};
            c    <= bit_c;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                sum       <= {bit_s, acc[WIDTH-1:1]};
                carry_out <= bit_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8); sub tests need SERIAL_ADDER_SUB_EN.
module tb_serial_adder;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic         cout;
        logic [W-1:0] s;
    } result_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    result_t sb[$];
    int n_vec  = 0;
    int n_miss = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] r;
        result_t    e;
        if (s) begin
            r = {1'b0, x} - {1'b0, y};
            e.cout = ~r[W];
        end else begin
            r = {1'b0, x} + {1'b0, y};
            e.cout = r[W];
        end
        e.s = r[W-1:0];
        return e;
    endfunction

    // Drive start for one cycle at a negedge and record the expected result.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        start = 1'b1;
        a     = x;
        b     = y;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = s;
`endif
        sb.push_back(model(x, y, s));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; cycles counts edges from the accept edge inclusive.
    task automatic wait_done(output int cycles, output int busy_n, output bit timeout);
        cycles = 1;
        busy_n = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            cycles++;
        end
        timeout = !done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, carry_out, sum} !== {3'b000, {W{1'b0}}}) begin
            n_miss++;
            $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, carry_out, sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc, bn;
        bit to;
        result_t e;
        issue(8'h03, 8'h05, 1'b0);
        wait_done(cyc, bn, to);
        e = sb.pop_front();
        n_vec++;
        if (to || cyc != W + 1) begin
            n_miss++;
            $display("FAIL basic_latency: got %0d cycles (timeout=%0b), want %0d", cyc, to, W + 1);
        end
        n_vec++;
        if (bn != W) begin
            n_miss++;
            $display("FAIL basic_busy: busy for %0d cycles, want %0d", bn, W);
        end
        n_vec++;
        if ({carry_out, sum} !== e) begin
            n_miss++;
            $display("FAIL basic_sum: got %b/%h, want %b/%h", carry_out, sum, e.cout, e.s);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== e.s) begin
            n_miss++;
            $display("FAIL basic_pulse: done=%b busy=%b sum=%h, want 0/0/%h", done, busy, sum, e.s);
        end
    endtask

    task automatic test_vec(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int cyc, bn;
        bit to;
        result_t e;
        logic [W-1:0] prev;
        prev = sum;
        issue(x, y, s);
        n_vec++;
        if (sum !== prev) begin
            n_miss++;
            $display("FAIL %s_hold: sum=%h during busy, want previous %h", name, sum, prev);
        end
        wait_done(cyc, bn, to);
        e = sb.pop_front();
        n_vec++;
        if (to || {carry_out, sum} !== e) begin
            n_miss++;
            $display("FAIL %s: got %b/%h (timeout=%0b), want %b/%h", name, carry_out, sum, to, e.cout, e.s);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        int cyc, bn, pulses;
        bit to;
        result_t e;
        issue(8'h10, 8'h20, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bn, to);
        e = sb.pop_front();
        n_vec++;
        if (to || {carry_out, sum} !== e) begin
            n_miss++;
            $display("FAIL busy_ignore: got %b/%h (timeout=%0b), want %b/%h", carry_out, sum, to, e.cout, e.s);
        end
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_miss++;
            $display("FAIL busy_ignore_extra: %0d busy/done cycles after result, want 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bn;
        bit to;
        result_t e;
        issue(8'h12, 8'h34, 1'b0);
        wait_done(cyc, bn, to);
        e = sb.pop_front();
        n_vec++;
        if (to || {carry_out, sum} !== e) begin
            n_miss++;
            $display("FAIL b2b_first: got %b/%h (timeout=%0b), want %b/%h", carry_out, sum, to, e.cout, e.s);
        end
        issue(8'h80, 8'h80, 1'b0);
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", busy, done);
        end
        wait_done(cyc, bn, to);
        e = sb.pop_front();
        n_vec++;
        if (to || cyc != W + 1 || {carry_out, sum} !== e) begin
            n_miss++;
            $display("FAIL b2b_second: got %b/%h after %0d cycles, want %b/%h after %0d",
                     carry_out, sum, cyc, e.cout, e.s, W + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int pulses;
        issue(8'h5A, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        n_vec++;
        if ({busy, done, carry_out, sum} !== {3'b000, {W{1'b0}}}) begin
            n_miss++;
            $display("FAIL reset_mid: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, carry_out, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_miss++;
            $display("FAIL reset_mid_quiet: %0d busy/done cycles after abort, want 0", pulses);
        end
        test_vec("after_reset", 8'hC3, 8'h4E, 1'b0);
    endtask

    task automatic test_random;
        logic [W-1:0] x, y;
        for (int i = 0; i < 6; i++) begin
            x = W'($urandom_range(0, 255));
            y = W'($urandom_range(0, 255));
            test_vec("random", x, y, 1'b0);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_vec("wrap", 8'hFF, 8'h01, 1'b0);
        test_vec("max", 8'hFF, 8'hFF, 1'b0);
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef SERIAL_ADDER_SUB_EN
        test_vec("sub_borrow", 8'h05, 8'h07, 1'b1);
        test_vec("sub_noborrow", 8'h07, 8'h05, 1'b1);
        test_vec("sub_equal", 8'h9C, 8'h9C, 1'b1);
`endif
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
